// File: rtl/disp_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : disp_arb_pkg
// Brief    : Shared types, constants and width helper for the display arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package disp_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHOW  = 2'd1,
        S_BLANK = 2'd2
    } arb_state_t;

    localparam logic [13:0] c_SEG_OFF = 14'h3FFF;

    // Ceiling log2, never below 1 so it can size a counter or index directly.
    function automatic int clog2(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) w++;
        return (w < 1) ? 1 : w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/disp_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : disp_tick_gen
// Brief    : Free-running DIV_N-bit prescaler; tick strobes when it is all-ones.
// Revision : 1.0 - initial release
// ============================================================================
module disp_tick_gen
    import disp_arb_pkg::*;
#(
    parameter int DIV_N = 25
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    logic [DIV_N-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + DIV_N'(1);
        end
    end

    assign tick = &r_cnt;

endmodule
`default_nettype wire

// File: rtl/disp_share_arb.sv
`default_nettype none
// ============================================================================
// Module   : disp_share_arb
// Brief    : Round-robin time-sharing of one active-low segment display.
// Options  : DISP_ARB_PRIO0_EN - requester 0 always wins and preempts others.
// Revision : 1.0 - initial release
// ============================================================================
module disp_share_arb
    import disp_arb_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int SEG_W       = 14,
    parameter int DIV_N       = 25,
    parameter int DWELL_TICKS = 4,
    parameter int BLANK_TICKS = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*SEG_W-1:0]   seg_in,
    output logic [N_REQ-1:0]         grant,
    output logic [N_REQ-1:0]         done,
    output logic [SEG_W-1:0]         disp,
    output logic [clog2(N_REQ)-1:0]  owner_idx,
    output logic                     tick
);

    localparam int IDX_W = clog2(N_REQ);
    localparam int DW_W  = clog2(DWELL_TICKS);
    localparam int BL_W  = clog2(BLANK_TICKS);

    localparam logic [IDX_W-1:0] c_LAST_IDX   = IDX_W'(N_REQ - 1);
    localparam logic [DW_W-1:0]  c_DWELL_LAST = DW_W'(DWELL_TICKS - 1);
    localparam logic [BL_W-1:0]  c_BLANK_LAST = BL_W'(BLANK_TICKS - 1);
    localparam logic [N_REQ-1:0] c_ONE        = N_REQ'(1);
    localparam arb_state_t       c_GAP        = (BLANK_TICKS == 0) ? S_IDLE : S_BLANK;

    arb_state_t         r_state;
    logic [N_REQ-1:0]   r_grant;
    logic [N_REQ-1:0]   r_done;
    logic [SEG_W-1:0]   r_disp;
    logic [IDX_W-1:0]   r_owner_idx;
    logic [DW_W-1:0]    r_dwell;
    logic [BL_W-1:0]    r_blank;

    logic               w_tick;
    logic               w_preempt;
    logic [IDX_W-1:0]   w_pick;
    logic [SEG_W-1:0]   w_seg [N_REQ];

    disp_tick_gen #(
        .DIV_N (DIV_N)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (w_tick)
    );

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign w_seg[g] = seg_in[g*SEG_W +: SEG_W];
    end

    // First requester after the last owner, wrapping; keeps last owner if none.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                                 input logic [IDX_W-1:0] last);
        logic [IDX_W-1:0] pick;
        logic [IDX_W-1:0] cand;
        logic             found;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = IDX_W'((int'(last) + k) % N_REQ);
            if (!found && r[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
`ifdef DISP_ARB_PRIO0_EN
        if (r[0]) pick = '0;
`endif
        return pick;
    endfunction

    assign w_pick = rr_pick(req, r_owner_idx);

`ifdef DISP_ARB_PRIO0_EN
    assign w_preempt = w_tick && req[0] && (r_owner_idx != '0);
`else
    assign w_preempt = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_grant     <= '0;
            r_done      <= '0;
            r_disp      <= '1;
            r_owner_idx <= c_LAST_IDX;
            r_dwell     <= '0;
            r_blank     <= '0;
        end else begin
            r_done <= '0;
            case (r_state)
                S_IDLE: begin
                    r_disp  <= '1;
                    r_grant <= '0;
                    if (|req) begin
                        r_grant     <= c_ONE << w_pick;
                        r_owner_idx <= w_pick;
                        r_dwell     <= '0;
                        r_state     <= S_SHOW;
                    end
                end
                S_SHOW: begin
                    // Release and preemption outrank a coincident dwell completion.
                    if (!req[r_owner_idx] || w_preempt) begin
                        r_grant <= '0;
                        r_disp  <= '1;
                        r_blank <= '0;
                        r_state <= c_GAP;
                    end else if (w_tick && (r_dwell == c_DWELL_LAST)) begin
                        r_done  <= r_grant;
                        r_grant <= '0;
                        r_disp  <= '1;
                        r_blank <= '0;
                        r_state <= c_GAP;
                    end else begin
                        r_disp <= ~w_seg[r_owner_idx];
                        if (w_tick) r_dwell <= r_dwell + DW_W'(1);
                    end
                end
                S_BLANK: begin
                    r_disp  <= '1;
                    r_grant <= '0;
                    if (w_tick) begin
                        if (r_blank == c_BLANK_LAST) begin
                            r_blank <= '0;
                            r_state <= S_IDLE;
                        end else begin
                            r_blank <= r_blank + BL_W'(1);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign grant     = r_grant;
    assign done      = r_done;
    assign disp      = r_disp;
    assign owner_idx = r_owner_idx;
    assign tick      = w_tick;

endmodule
`default_nettype wire

// File: tb/tb_disp_share_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_disp_share_arb
// Brief    : Scoreboard bench for disp_share_arb (N_REQ=4, DIV_N=2, dwell 2, blank 1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_disp_share_arb;

    localparam int N_REQ       = 4;
    localparam int SEG_W       = 14;
    localparam int DIV_N       = 2;
    localparam int DWELL_TICKS = 2;
    localparam int BLANK_TICKS = 1;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [N_REQ-1:0]       req;
    logic [N_REQ*SEG_W-1:0] seg_in;
    logic [N_REQ-1:0]       grant;
    logic [N_REQ-1:0]       done;
    logic [SEG_W-1:0]       disp;
    logic [1:0]             owner_idx;
    logic                   tick;

    int                     n_checks = 0;
    int                     n_errors = 0;
    logic [N_REQ-1:0]       sb_grant [$];
    logic [N_REQ-1:0]       prev_grant = '0;
    logic [N_REQ-1:0]       exp_owner  = '0;
    logic [N_REQ*SEG_W-1:0] seg_edge;
    logic [SEG_W-1:0]       exp_disp;
    int                     done_cnt [N_REQ];
    int                     exp_done [N_REQ];
    bit                     mon_en = 1'b0;
    int                     n1;
    int                     n2;

    disp_share_arb #(
        .N_REQ       (N_REQ),
        .SEG_W       (SEG_W),
        .DIV_N       (DIV_N),
        .DWELL_TICKS (DWELL_TICKS),
        .BLANK_TICKS (BLANK_TICKS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .seg_in    (seg_in),
        .grant     (grant),
        .done      (done),
        .disp      (disp),
        .owner_idx (owner_idx),
        .tick      (tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int oh2idx(input logic [N_REQ-1:0] v);
        int r;
        r = 0;
        for (int i = 0; i < N_REQ; i++) if (v[i]) r = i;
        return r;
    endfunction

    // Segment data as the DUT saw it at the most recent rising edge.
    always @(posedge clk) seg_edge <= seg_in;

    always @(negedge clk) begin
        if (mon_en) begin
            check("grant_onehot0", {31'b0, $onehot0(grant)}, 32'd1);
            exp_disp = '1;
            if (grant != '0 && grant == prev_grant)
                exp_disp = ~seg_edge[oh2idx(exp_owner)*SEG_W +: SEG_W];
            check("disp", disp, exp_disp);
            if (grant != '0 && grant != prev_grant) begin
                if (sb_grant.size() == 0) begin
                    check("grant_unexpected", grant, 0);
                end else begin
                    exp_owner = sb_grant.pop_front();
                    check("grant_order", grant, exp_owner);
                end
            end
            if (done != '0) begin
                check("done_owner", done, exp_owner);
                check("done_grant_cleared", grant, 0);
                for (int i = 0; i < N_REQ; i++) if (done[i]) done_cnt[i]++;
            end
        end
        prev_grant = grant;
    end

    task automatic wait_sb_empty(input string tag);
        int k;
        k = 0;
        while (sb_grant.size() != 0 && k < 400) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (sb_grant.size() != 0) begin
            check({tag, "_grant_timeout"}, sb_grant.size(), 0);
            sb_grant.delete();
        end
    endtask

    task automatic wait_grant_zero(input string tag);
        int k;
        k = 0;
        while (grant != '0 && k < 100) begin
            @(negedge clk);
            #1;
            k++;
        end
        check({tag, "_release"}, grant, 0);
    endtask

    initial begin
        for (int i = 0; i < N_REQ; i++) begin
            done_cnt[i] = 0;
            seg_in[i*SEG_W +: SEG_W] = SEG_W'(1 << i);
        end
`ifdef DISP_ARB_PRIO0_EN
        exp_done = '{5, 2, 0, 3};
`else
        exp_done = '{2, 3, 2, 4};
`endif
        rst_n = 1'b0;
        req   = 4'b1111;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_grant", grant, 0);
        check("rst_disp", disp, 14'h3FFF);
        check("rst_done", done, 0);
        check("rst_owner_idx", owner_idx, 3);
        check("rst_tick", tick, 0);

        // Full round-robin with every requester active
`ifdef DISP_ARB_PRIO0_EN
        for (int i = 0; i < 5; i++) sb_grant.push_back(4'b0001);
`else
        sb_grant.push_back(4'b0001);
        sb_grant.push_back(4'b0010);
        sb_grant.push_back(4'b0100);
        sb_grant.push_back(4'b1000);
        sb_grant.push_back(4'b0001);
`endif
        mon_en = 1'b1;
        rst_n  = 1'b1;
        wait_sb_empty("rr");
        wait_grant_zero("rr");

        // Sparse requests alternate between requesters 1 and 3
        req = 4'b1010;
        for (int i = 0; i < 2; i++) begin
            sb_grant.push_back(4'b0010);
            sb_grant.push_back(4'b1000);
        end
        wait_sb_empty("sparse");
        wait_grant_zero("sparse");

        // Early release of requester 1
        sb_grant.push_back(4'b0010);
        wait_sb_empty("er_own1");
        n1  = done_cnt[1];
        req = 4'b1000;
        sb_grant.push_back(4'b1000);
        @(posedge clk);
        @(negedge clk);
        check("er_grant", grant, 0);
        check("er_disp", disp, 14'h3FFF);
        check("er_no_done", done, 0);
        wait_sb_empty("er_own3");
        check("er_done1_count", done_cnt[1], n1);
        wait_grant_zero("er");

        // Live content change while requester 2 owns the display
        req = 4'b0100;
        seg_in[2*SEG_W +: SEG_W] = 14'h00FF;
        sb_grant.push_back(4'b0100);
        wait_sb_empty("live");
        @(negedge clk);
        check("live_first", disp, 14'h3F00);
        @(posedge clk);
        #1;
        seg_in[2*SEG_W +: SEG_W] = 14'h0F00;
        @(negedge clk);
        check("live_latency", disp, 14'h3F00);
        @(negedge clk);
        check("live_updated", disp, 14'h30FF);

        // Requester 0 arrives while requester 2 is showing
        @(posedge clk);
        #1;
        n2  = done_cnt[2];
        req = 4'b0101;
        sb_grant.push_back(4'b0001);
        wait_sb_empty("prio");
`ifdef DISP_ARB_PRIO0_EN
        check("prio_done2_count", done_cnt[2], n2);
`else
        check("prio_done2_count", done_cnt[2], n2 + 1);
`endif
        req = 4'b0000;
        wait_grant_zero("final");
        repeat (20) @(negedge clk);
        #1;
        check("idle_grant", grant, 0);
        check("idle_disp", disp, 14'h3FFF);
        for (int i = 0; i < N_REQ; i++) check($sformatf("done_count_%0d", i), done_cnt[i], exp_done[i]);
        check("sb_leftover", sb_grant.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/disp_share_arb.md
Name: disp_share_arb

Overview:
- Time-shares the board's single 14-segment display between N_REQ requesters, e.g. the pattern scroller, the key decoder and the status readout.
- Internal prescaler sets dwell and blank-gap time; owner selection is round-robin.
- Registered active-low drive goes straight to the disp pins.
- Sits between the content generators and the top-level disp output.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- SEG_W, 14, segment vector width
- DIV_N, 25, prescaler width; one tick every 2**DIV_N clk cycles
- DWELL_TICKS, 4, ticks an owner holds the display (>=1)
- BLANK_TICKS, 1, ticks of all-off gap between owners (0 = no gap)

Ports:
- clk, input, 1, system clock
- rst_n, input, 1, synchronous active-low reset
- req, input, N_REQ, level request per requester
- seg_in, input, N_REQ*SEG_W, active-high segment patterns; requester i at [i*SEG_W +: SEG_W]
- grant, output, N_REQ, one-hot current owner, registered
- done, output, N_REQ, one-cycle pulse when owner's dwell completes
- disp, output, SEG_W, active-low segment drive, registered; all-ones = dark
- owner_idx, output, clog2(N_REQ), index of current/last owner
- tick, output, 1, prescaler strobe (debug LED)

Behaviour:
- Reset (rst_n low at posedge clk):
  - state=IDLE, grant=0, done=0, disp='1 (all off)
  - owner_idx=N_REQ-1, so requester 0 is first to be scanned
  - prescaler=0, dwell/blank counters=0
- Prescaler: free-running DIV_N-bit up-counter, wraps. tick=1 for exactly one cycle when counter==all-ones.
- IDLE:
  - disp='1.
  - If any req is high, pick the first set bit scanning from owner_idx+1, wrapping modulo N_REQ.
  - Next cycle: grant=onehot(pick), owner_idx=pick, state=SHOW, dwell counter=0.
  - Latency req->grant is 1 cycle.
- SHOW:
  - disp <= ~seg_in[owner], updated every cycle (1-cycle latency, so live content may change).
  - Each tick increments the dwell counter.
  - On the tick where the counter equals DWELL_TICKS-1: done[owner]=1 for one cycle, grant=0, enter BLANK (or IDLE if BLANK_TICKS=0).
- Early release: req[owner] low during SHOW -> next cycle grant=0, disp='1, enter BLANK, no done pulse.
- BLANK:
  - disp='1, grant=0.
  - Count ticks; after BLANK_TICKS ticks enter IDLE. Arbitration happens in IDLE on the following cycle.
- Fairness: a requester holding req high continuously is re-granted only after every other active requester has had one turn.
- Dwell boundary:
  - The first tick counted may arrive 1..2**DIV_N cycles after grant (prescaler is not resynced).
  - Dwell is therefore between DWELL_TICKS-1 and DWELL_TICKS tick periods; this is accepted.
- Simultaneous tick and early release: early release wins; no done pulse.
- Reset mid-SHOW: outputs go to reset values on the same edge; no done pulse.
- Invariants: grant is one-hot or zero. done is only ever asserted on the bit that was granted in the previous cycle.

Optional Feature:
- Macro: DISP_ARB_PRIO0_EN.
- Defined:
  - Requester 0 wins every IDLE arbitration regardless of round-robin pointer.
  - If req[0] rises while another requester is in SHOW, the owner is preempted at the next tick: grant=0, no done pulse, enter BLANK.
  - Requester 0 itself is never preempted.
- Undefined: pure round-robin; req[0] has no special treatment.

Decomposition:
- Package disp_arb_pkg:
  - state enum {IDLE, SHOW, BLANK}
  - SEG_OFF constant = all-ones of SEG_W (14'h3FFF)
  - clog2 helper for owner_idx width
- Sub-module disp_tick_gen: DIV_N prescaler producing tick. Reused for the LED pattern stepping.
- Round-robin pick stays inline as a combinational function.

Test Plan:
All tests use DIV_N=2 (tick every 4 cycles), DWELL_TICKS=2, BLANK_TICKS=1, N_REQ=4.
- Reset: hold rst_n=0 for 3 cycles with req=4'b1111 -> grant=0, disp=14'h3FFF, done=0. First grant after release is 4'b0001.
- Round-robin: req=4'b1111 held, seg_in[i]=14'h0001<<i -> grant order 0001,0010,0100,1000,0001. done pulses once per owner. disp=~(1<<i) while owner i, 14'h3FFF during each blank.
- Sparse requests: req=4'b1010 -> alternates 0010/1000. Owner indices 0 and 2 are never granted.
- Early release: owner 1 granted, drop req[1] mid-dwell -> grant=0 next cycle, no done[1], disp=14'h3FFF, then owner 3 is granted.
- Live update: change seg_in[2] from 14'h00FF to 14'h0F00 during owner 2's SHOW -> disp moves from 14'h3F00 to 14'h30FF one cycle later.
- With DISP_ARB_PRIO0_EN: owner 2 in SHOW, raise req[0] -> at next tick grant=0 with no done[2]; after the blank, grant=0001. Without the macro, owner 2 completes its dwell and done[2] pulses.
